// File: rtl/dcache_controller.sv
// Data-cache control stage: combinational hit path into the 2-way SRAM, plus an
// FSM sequencing dirty write-back, line refill and re-lookup on a miss.
module dcache_controller (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [31:0]  cpu_addr_i,
  input  logic [31:0]  cpu_data_i,
  input  logic         cpu_MemRead_i,
  input  logic         cpu_MemWrite_i,
  output logic [31:0]  cpu_data_o,
  output logic         cpu_stall_o,
  output logic [3:0]   sram_addr_o,
  output logic [24:0]  sram_tag_o,
  output logic [255:0] sram_data_o,
  output logic         sram_enable_o,
  output logic         sram_write_o,
  input  logic [24:0]  sram_tag_i,
  input  logic [255:0] sram_data_i,
  input  logic         sram_hit_i,
  output logic [31:0]  mem_addr_o,
  output logic [255:0] mem_data_o,
  output logic         mem_enable_o,
  output logic         mem_write_o,
  input  logic [255:0] mem_data_i,
  input  logic         mem_ack_i
);

  typedef enum logic [2:0] {
    IDLE,
    MISS,
    WRITEBACK,
    READMISS,
    READMISSOK
  } state_t;

  state_t         state;
  logic           req;
  logic [3:0]     index;
  logic [22:0]    cpu_tag;
  logic [7:0]     bit_off;
  logic           victim_dirty;
  logic [255:0]   merged;

  always_comb begin
    req          = cpu_MemRead_i | cpu_MemWrite_i;
    index        = cpu_addr_i[8:5];
    cpu_tag      = cpu_addr_i[31:9];
    bit_off      = {cpu_addr_i[4:2], 5'b0};
    victim_dirty = sram_tag_i[24] & sram_tag_i[23];
    merged                = sram_data_i;
    merged[bit_off +: 32] = cpu_data_i;

    sram_addr_o   = index;
    sram_tag_o    = {2'b11, cpu_tag};
    sram_data_o   = merged;
    sram_enable_o = 1'b0;
    sram_write_o  = 1'b0;
    cpu_stall_o   = 1'b0;
    cpu_data_o    = '0;

    // Every CPU/SRAM-facing control is forced quiet while reset is asserted.
    if (rst_i) begin
      case (state)
        IDLE: begin
          sram_enable_o = req;
          cpu_stall_o   = req & ~sram_hit_i;
          if (req & sram_hit_i) begin
            if (cpu_MemWrite_i) sram_write_o = 1'b1;
            else                cpu_data_o   = sram_data_i[bit_off +: 32];
          end
        end
        MISS: begin
          sram_enable_o = req;
          cpu_stall_o   = 1'b1;
        end
        WRITEBACK: cpu_stall_o = 1'b1;
        READMISS: begin
          sram_enable_o = 1'b1;
          cpu_stall_o   = 1'b1;
          if (mem_ack_i) begin
            sram_write_o = 1'b1;
            sram_data_o  = mem_data_i;
            sram_tag_o   = {2'b10, cpu_tag};
          end
        end
        READMISSOK: begin
          sram_enable_o = 1'b1;
          cpu_stall_o   = 1'b1;
        end
        default: cpu_stall_o = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state        <= IDLE;
      mem_enable_o <= 1'b0;
      mem_write_o  <= 1'b0;
      mem_addr_o   <= '0;
      mem_data_o   <= '0;
    end else begin
      mem_enable_o <= 1'b0;
      case (state)
        IDLE: if (req & ~sram_hit_i) state <= MISS;
        MISS: begin
          mem_enable_o <= 1'b1;
          if (victim_dirty) begin
            mem_addr_o  <= {sram_tag_i[22:0], index, 5'b0};
            mem_data_o  <= sram_data_i;
            mem_write_o <= 1'b1;
            state       <= WRITEBACK;
          end else begin
            mem_addr_o  <= {cpu_tag, index, 5'b0};
            mem_write_o <= 1'b0;
            state       <= READMISS;
          end
        end
        WRITEBACK: if (mem_ack_i) begin
          mem_enable_o <= 1'b1;
          mem_write_o  <= 1'b0;
          mem_addr_o   <= {cpu_tag, index, 5'b0};
          state        <= READMISS;
        end
        READMISS:   if (mem_ack_i) state <= READMISSOK;
        READMISSOK: state <= IDLE;
        default:    state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dcache_controller.sv
// Bench for dcache_controller: behavioural 2-way SRAM and latency-programmable
// memory around the DUT, checked against a flat word-addressed reference memory.
module tb_dcache_controller;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_i, rd, wr;
  logic [31:0]  cpu_addr, cpu_wdata, cpu_data_o;
  logic         cpu_stall_o;
  logic [3:0]   sram_addr_o;
  logic [24:0]  sram_tag_o, sram_tag_i;
  logic [255:0] sram_data_o, sram_data_i;
  logic         sram_enable_o, sram_write_o, sram_hit_i;
  logic [31:0]  mem_addr_o;
  logic [255:0] mem_data_o, mem_rdata;
  logic         mem_enable_o, mem_write_o;
  logic         mem_ack_m, ack_force, mem_ack_i;
  assign mem_ack_i = mem_ack_m | ack_force;

  dcache_controller dut (
    .clk_i(clk), .rst_i(rst_i),
    .cpu_addr_i(cpu_addr), .cpu_data_i(cpu_wdata),
    .cpu_MemRead_i(rd), .cpu_MemWrite_i(wr),
    .cpu_data_o(cpu_data_o), .cpu_stall_o(cpu_stall_o),
    .sram_addr_o(sram_addr_o), .sram_tag_o(sram_tag_o), .sram_data_o(sram_data_o),
    .sram_enable_o(sram_enable_o), .sram_write_o(sram_write_o),
    .sram_tag_i(sram_tag_i), .sram_data_i(sram_data_i), .sram_hit_i(sram_hit_i),
    .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o),
    .mem_enable_o(mem_enable_o), .mem_write_o(mem_write_o),
    .mem_data_i(mem_rdata), .mem_ack_i(mem_ack_i)
  );

  int tests = 0;
  int fails = 0;

  // Reference memory state: words written by the CPU, lines written back.
  logic [31:0]  ref_words [logic [29:0]];
  logic [255:0] mem_lines [logic [26:0]];
  int           mem_lat = 1;

  function automatic logic [31:0] init_word(input logic [29:0] wa);
    return ({2'b00, wa} * 32'h9E37_79B9) ^ 32'h5A5A_0000;
  endfunction

  function automatic logic [255:0] get_line(input logic [26:0] la);
    logic [255:0] l;
    if (mem_lines.exists(la)) return mem_lines[la];
    for (int i = 0; i < 8; i++) l[i*32 +: 32] = init_word({la, 3'(i)});
    return l;
  endfunction

  function automatic logic [31:0] get_ref(input logic [31:0] a);
    if (ref_words.exists(a[31:2])) return ref_words[a[31:2]];
    return init_word(a[31:2]);
  endfunction

  // Behavioural 2-way SRAM with per-set LRU bit pointing at the victim way.
  logic [24:0]  tags  [16][2];
  logic [255:0] lines [16][2];
  logic         lru   [16];
  int           sram_writes = 0;

  always_comb begin
    sram_hit_i  = 1'b0;
    sram_tag_i  = '0;
    sram_data_i = '0;
    for (int w = 0; w < 2; w++)
      if (tags[sram_addr_o][w][24] && tags[sram_addr_o][w][22:0] == cpu_addr[31:9]) begin
        sram_hit_i  = 1'b1;
        sram_tag_i  = tags[sram_addr_o][w];
        sram_data_i = lines[sram_addr_o][w];
      end
    if (!sram_hit_i) begin
      sram_tag_i  = tags[sram_addr_o][lru[sram_addr_o]][24] ? tags[sram_addr_o][lru[sram_addr_o]] : '0;
      sram_data_i = lines[sram_addr_o][lru[sram_addr_o]];
    end
  end

  logic         p_en, p_we, p_found, p_way;
  logic [3:0]   p_set;
  logic [24:0]  p_tag;
  logic [22:0]  p_ct;
  logic [255:0] p_data;
  always begin
    @(negedge clk);
    p_en = sram_enable_o; p_we = sram_write_o; p_set = sram_addr_o;
    p_tag = sram_tag_o; p_data = sram_data_o; p_ct = cpu_addr[31:9];
    @(posedge clk);
    if (p_en) begin
      p_way = lru[p_set]; p_found = 1'b0;
      for (int w = 0; w < 2; w++)
        if (tags[p_set][w][24] && tags[p_set][w][22:0] == p_ct) begin
          p_way = 1'(w); p_found = 1'b1;
        end
      if (p_we) begin
        tags[p_set][p_way]  = p_tag;
        lines[p_set][p_way] = p_data;
        lru[p_set]          = ~p_way;
        sram_writes++;
      end else if (p_found) lru[p_set] = ~p_way;
    end
  end

  // Memory: ack mem_lat cycles after the request pulse.
  logic [26:0]  r_la;
  logic         r_wr;
  logic [255:0] r_line;
  initial begin
    mem_ack_m = 1'b0; mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (rst_i === 1'b1 && mem_enable_o === 1'b1) begin
        r_la = mem_addr_o[31:5]; r_wr = mem_write_o;
        if (r_wr) mem_lines[r_la] = mem_data_o;
        r_line = get_line(r_la);
        repeat (mem_lat) @(posedge clk);
        #1 mem_ack_m = 1'b1; mem_rdata = r_wr ? '0 : r_line;
        @(posedge clk);
        #1 mem_ack_m = 1'b0;
      end
    end
  end

  typedef struct packed {
    logic [31:0]  addr;
    logic         wr;
    logic [255:0] data;
  } mreq_t;
  mreq_t reqs[$];
  logic  prev_en = 1'b0;
  int    consec_err = 0;
  always @(negedge clk) begin
    if (rst_i === 1'b1 && mem_enable_o === 1'b1) reqs.push_back({mem_addr_o, mem_write_o, mem_data_o});
    if (mem_enable_o === 1'b1 && prev_en) consec_err++;
    prev_en = (mem_enable_o === 1'b1);
  end

  // Starts at posedge+1; holds the request until a stall-free cycle is seen.
  task automatic access(input logic w, input logic r, input logic [31:0] a, input logic [31:0] d,
                        output int stall, output logic [31:0] q, output logic timeout);
    cpu_addr = a; cpu_wdata = d; rd = r; wr = w;
    stall = 0; timeout = 1'b0; q = '0;
    while (1) begin
      @(negedge clk);
      if (cpu_stall_o === 1'b0) begin q = cpu_data_o; break; end
      stall++;
      if (stall > 200) begin timeout = 1'b1; break; end
    end
    @(posedge clk); #1;
    rd = 1'b0; wr = 1'b0;
  endtask

  function automatic void predict(input logic [31:0] a, output logic hit, output logic dirty,
                                  output logic [31:0] vaddr, output logic [255:0] vdata);
    logic [3:0] s;
    logic       v;
    s = a[8:5]; hit = 1'b0;
    for (int w = 0; w < 2; w++)
      if (tags[s][w][24] && tags[s][w][22:0] == a[31:9]) hit = 1'b1;
    v     = lru[s];
    dirty = !hit && tags[s][v][24] && tags[s][v][23];
    vaddr = {tags[s][v][22:0], s, 5'b0};
    vdata = lines[s][v];
  endfunction

  task automatic test_reset();
    rst_i = 1'b0; ack_force = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    tests++;
    if (mem_enable_o !== 1'b0 || mem_write_o !== 1'b0 || mem_addr_o !== '0 || mem_data_o !== '0)
      $display("FAIL reset_mem_regs: en=%b wr=%b addr=%h expected all 0", mem_enable_o, mem_write_o, mem_addr_o);
      fails += (mem_enable_o !== 1'b0 || mem_write_o !== 1'b0 || mem_addr_o !== '0 || mem_data_o !== '0) ? 1 : 0;
    tests++;
    if (cpu_stall_o !== 1'b0 || sram_enable_o !== 1'b0 || sram_write_o !== 1'b0 || cpu_data_o !== '0) begin
      fails++;
      $display("FAIL reset_comb: stall=%b en=%b we=%b data=%h expected 0", cpu_stall_o, sram_enable_o, sram_write_o, cpu_data_o);
    end
    @(posedge clk); #1 rst_i = 1'b1; ack_force = 1'b0;
    @(negedge clk);
    tests++;
    if (cpu_stall_o !== 1'b0 || mem_enable_o !== 1'b0) begin
      fails++;
      $display("FAIL reset_idle: stall=%b mem_en=%b expected 0 0", cpu_stall_o, mem_enable_o);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_load_miss();
    int st; logic [31:0] q; logic to; logic [255:0] l; logic ok;
    l = get_line(27'h8); l[63:32] = 32'hDEAD_BEEF;
    mem_lines[27'h8] = l; ref_words[30'h41] = 32'hDEAD_BEEF;
    mem_lat = 10; reqs.delete();
    access(1'b0, 1'b1, 32'h0000_0104, '0, st, q, to);
    tests++;
    if (to || st != 14) begin fails++; $display("FAIL load_miss_stall: got %0d cycles expected 14", st); end
    tests++;
    if (reqs.size() != 1 || reqs[0].addr !== 32'h100 || reqs[0].wr !== 1'b0) begin
      fails++; $display("FAIL load_miss_req: %0d requests, first addr %h, expected one read of 00000100", reqs.size(), reqs[0].addr);
    end
    ok = (tags[8][0] === 25'h100_0000) || (tags[8][1] === 25'h100_0000);
    tests++;
    if (!ok) begin fails++; $display("FAIL load_miss_tag: got %h/%h expected 1000000", tags[8][0], tags[8][1]); end
    tests++;
    if (q !== 32'hDEAD_BEEF) begin fails++; $display("FAIL load_miss_data: got %h expected deadbeef", q); end
  endtask

  task automatic test_store_hit();
    int st; logic [31:0] q; logic to; int way;
    reqs.delete();
    access(1'b1, 1'b0, 32'h0000_0108, 32'h1234_5678, st, q, to);
    ref_words[30'h42] = 32'h1234_5678;
    tests++;
    if (to || st != 0 || reqs.size() != 0) begin
      fails++; $display("FAIL store_hit_stall: stall %0d requests %0d expected 0 0", st, reqs.size());
    end
    way = (tags[8][1][24] && tags[8][1][22:0] == 23'd0) ? 1 : 0;
    tests++;
    if (tags[8][way][23] !== 1'b1 || lines[8][way][95:64] !== 32'h1234_5678 || lines[8][way][63:32] !== 32'hDEAD_BEEF) begin
      fails++; $display("FAIL store_hit_merge: tag %h word2 %h expected dirty and 12345678", tags[8][way], lines[8][way][95:64]);
    end
  endtask

  task automatic test_dirty_miss();
    int st; logic [31:0] q; logic to; logic [255:0] v;
    for (int i = 0; i < 8; i++) begin
      v[i*32 +: 32] = $urandom;
      ref_words[{23'd1, 4'd0, 3'(i)}] = v[i*32 +: 32];
    end
    tags[0][0] = {2'b11, 23'd1}; lines[0][0] = v;
    tags[0][1] = {2'b10, 23'd3}; lines[0][1] = get_line({23'd3, 4'd0});
    lru[0] = 1'b0;
    mem_lat = 4; reqs.delete();
    access(1'b0, 1'b1, 32'h0000_0010, '0, st, q, to);
    tests++;
    if (to || st != 13) begin fails++; $display("FAIL dirty_miss_stall: got %0d expected 13", st); end
    tests++;
    if (reqs.size() != 2 || reqs[0].addr !== 32'h200 || reqs[0].wr !== 1'b1 || reqs[0].data !== v ||
        reqs[1].addr !== 32'h0 || reqs[1].wr !== 1'b0) begin
      fails++; $display("FAIL dirty_miss_reqs: %0d requests, %h/%b then %h/%b expected 200/1 then 0/0",
                        reqs.size(), reqs[0].addr, reqs[0].wr, reqs[1].addr, reqs[1].wr);
    end
    tests++;
    if (q !== get_ref(32'h10)) begin fails++; $display("FAIL dirty_miss_data: got %h expected %h", q, get_ref(32'h10)); end
    tests++;
    if (get_line(27'h10) !== v) begin fails++; $display("FAIL dirty_miss_wb: memory line 200 not updated with victim"); end
  endtask

  task automatic test_both_ops();
    int st; logic [31:0] q; logic to;
    reqs.delete();
    access(1'b1, 1'b1, 32'h0000_0014, 32'hCAFE_F00D, st, q, to);
    ref_words[30'h5] = 32'hCAFE_F00D;
    tests++;
    if (to || st != 0 || reqs.size() != 0) begin fails++; $display("FAIL both_ops_stall: stall %0d requests %0d expected 0 0", st, reqs.size()); end
    access(1'b0, 1'b1, 32'h0000_0014, '0, st, q, to);
    tests++;
    if (q !== 32'hCAFE_F00D) begin fails++; $display("FAIL both_ops_store: got %h expected cafef00d", q); end
  endtask

  task automatic test_spurious_ack();
    int st; logic [31:0] q; logic to; int w0;
    w0 = sram_writes; reqs.delete();
    ack_force = 1'b1;
    @(negedge clk);
    tests++;
    if (cpu_stall_o !== 1'b0 || sram_write_o !== 1'b0) begin
      fails++; $display("FAIL spurious_ack_comb: stall=%b we=%b expected 0 0", cpu_stall_o, sram_write_o);
    end
    @(posedge clk); #1 ack_force = 1'b0;
    @(negedge clk);
    tests++;
    if (mem_enable_o !== 1'b0 || sram_writes != w0 || reqs.size() != 0) begin
      fails++; $display("FAIL spurious_ack_state: mem_en=%b writes %0d expected 0 %0d", mem_enable_o, sram_writes, w0);
    end
    @(posedge clk); #1;
    access(1'b0, 1'b1, 32'h0000_0014, '0, st, q, to);
    tests++;
    if (to || st != 0 || q !== 32'hCAFE_F00D) begin fails++; $display("FAIL spurious_ack_hit: stall %0d data %h expected 0 cafef00d", st, q); end
  endtask

  task automatic test_reset_mid_miss();
    int st; logic [31:0] q; logic to; int w0;
    mem_lat = 10; reqs.delete(); w0 = sram_writes;
    cpu_addr = 32'h0000_0400; rd = 1'b1; wr = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst_i = 1'b0;
    @(negedge clk);
    tests++;
    if (cpu_stall_o !== 1'b0 || sram_enable_o !== 1'b0 || sram_write_o !== 1'b0 || cpu_data_o !== '0) begin
      fails++; $display("FAIL midmiss_reset_comb: stall=%b en=%b we=%b expected 0", cpu_stall_o, sram_enable_o, sram_write_o);
    end
    @(posedge clk); @(negedge clk);
    tests++;
    if (mem_enable_o !== 1'b0 || mem_write_o !== 1'b0 || mem_addr_o !== '0 || mem_data_o !== '0) begin
      fails++; $display("FAIL midmiss_reset_regs: en=%b addr=%h expected 0", mem_enable_o, mem_addr_o);
    end
    @(posedge clk); #1 rst_i = 1'b1; rd = 1'b0;
    repeat (12) @(negedge clk);
    tests++;
    if (sram_writes != w0 || reqs.size() != 1 || cpu_stall_o !== 1'b0) begin
      fails++; $display("FAIL midmiss_late_ack: writes %0d requests %0d stall %b expected %0d 1 0", sram_writes, reqs.size(), cpu_stall_o, w0);
    end
    @(posedge clk); #1;
    mem_lat = 3;
    access(1'b0, 1'b1, 32'h0000_0400, '0, st, q, to);
    tests++;
    if (to || st != 7 || q !== get_ref(32'h400)) begin
      fails++; $display("FAIL midmiss_retry: stall %0d data %h expected 7 %h", st, q, get_ref(32'h400));
    end
  endtask

  task automatic test_random();
    int st, exp_st, exp_n, lat, op; logic [31:0] q, a, d, vaddr; logic to, hit, dirty; logic [255:0] vdata;
    for (int it = 0; it < 60; it++) begin
      a = {23'($urandom_range(0, 3)), 4'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3))};
      op = $urandom_range(0, 2); d = $urandom; lat = $urandom_range(1, 5);
      predict(a, hit, dirty, vaddr, vdata);
      exp_st = hit ? 0 : (dirty ? 2 * lat + 5 : lat + 4);
      exp_n  = hit ? 0 : (dirty ? 2 : 1);
      mem_lat = lat; reqs.delete();
      access(op != 0, op != 1, a, d, st, q, to);
      tests++;
      if (to || st != exp_st) begin fails++; $display("FAIL rand_stall[%0d]: addr %h got %0d expected %0d", it, a, st, exp_st); end
      tests++;
      if (reqs.size() != exp_n ||
          (dirty && (reqs[0].addr !== vaddr || reqs[0].wr !== 1'b1 || reqs[0].data !== vdata)) ||
          (!hit && (reqs[exp_n-1].addr !== {a[31:5], 5'b0} || reqs[exp_n-1].wr !== 1'b0))) begin
        fails++; $display("FAIL rand_reqs[%0d]: addr %h got %0d requests expected %0d", it, a, reqs.size(), exp_n);
      end
      if (op == 0) begin
        tests++;
        if (q !== get_ref(a)) begin fails++; $display("FAIL rand_load[%0d]: addr %h got %h expected %h", it, a, q, get_ref(a)); end
      end else ref_words[a[31:2]] = d;
    end
  endtask

  task automatic test_pulse_spacing();
    tests++;
    if (consec_err != 0) begin fails++; $display("FAIL pulse_spacing: %0d back-to-back mem_enable cycles expected 0", consec_err); end
  endtask

  initial begin
    rst_i = 1'b0; rd = 1'b0; wr = 1'b0; ack_force = 1'b0;
    cpu_addr = '0; cpu_wdata = '0;
    for (int s = 0; s < 16; s++) begin
      lru[s] = 1'b0;
      for (int w = 0; w < 2; w++) begin tags[s][w] = '0; lines[s][w] = '0; end
    end
    test_reset();
    test_load_miss();
    test_store_hit();
    test_dirty_miss();
    test_both_ops();
    test_spurious_ack();
    test_reset_mid_miss();
    test_random();
    test_pulse_spacing();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
